// File: rtl/reg_file_sb.sv
// -----------------------------------------------------------------------------
// reg_file_sb
//
// Purpose:
//   Multi-read-port data register file with a per-register busy scoreboard.
//   Decode reserves destination registers (rsv/addr_rsv) and reads operands
//   together with their busy status; writeback writes results (we/addr_rd/rd)
//   and clears the matching busy bit. A same-cycle write is forwarded to any
//   read port addressing the written register. Optionally register 0 is
//   hard-wired to zero and can never become busy.
//
// Ports:
//   clock     in   rising-edge clock
//   reset     in   asynchronous, active-high; clears all state
//   we        in   write enable (writeback)
//   addr_rd   in   [SZB-1:0]      write address
//   rd        in   [BIT-1:0]      write data
//   rsv       in   reserve request: mark addr_rsv busy
//   addr_rsv  in   [SZB-1:0]      register to reserve
//   addr_rs   in   [NRD*SZB-1:0]  read addresses, port i at [SZB*i +: SZB]
//   rs        out  [NRD*BIT-1:0]  registered read data, port i at [BIT*i +: BIT]
//   rs_busy   out  [NRD-1:0]      registered busy flag per read port
//   n_busy    out  [SZB:0]        registered count of busy registers
// -----------------------------------------------------------------------------
module reg_file_sb #(
    parameter int BIT     = 8,
    parameter int SZB     = 4,
    parameter int NRD     = 2,
    parameter int ZERO_R0 = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               we,
    input  logic [SZB-1:0]     addr_rd,
    input  logic [BIT-1:0]     rd,
    input  logic               rsv,
    input  logic [SZB-1:0]     addr_rsv,
    input  logic [NRD*SZB-1:0] addr_rs,
    output logic [NRD*BIT-1:0] rs,
    output logic [NRD-1:0]     rs_busy,
    output logic [SZB:0]       n_busy
);

    localparam int SZA = 1 << SZB;

    // Storage and scoreboard state
    logic [BIT-1:0]     regf_q [SZA];
    logic [SZA-1:0]     busy_q;
    logic [SZA-1:0]     busy_d;

    // Registered outputs
    logic [NRD*BIT-1:0] rs_q;
    logic [NRD*BIT-1:0] rs_d;
    logic [NRD-1:0]     rs_busy_q;
    logic [NRD-1:0]     rs_busy_d;
    logic [SZB:0]       n_busy_q;
    logic [SZB:0]       n_busy_d;

    // -------------------------------------------------------------------------
    // Per-register storage and busy next-state
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < SZA; gi++) begin : g_reg
            localparam bit IS_ZERO = (ZERO_R0 != 0) && (gi == 0);

            logic wr_hit;
            logic rsv_hit;

            assign wr_hit  = we  && (addr_rd  == SZB'(gi));
            assign rsv_hit = rsv && (addr_rsv == SZB'(gi));

            if (IS_ZERO) begin : g_zero
                assign busy_d[gi] = 1'b0;
            end else begin : g_norm
                // A new reservation outranks a same-cycle writeback: the
                // younger producer owns the register from this edge on.
                assign busy_d[gi] = rsv_hit ? 1'b1 :
                                    wr_hit  ? 1'b0 : busy_q[gi];
            end

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    regf_q[gi] <= '0;
                end else if (wr_hit && !IS_ZERO) begin
                    regf_q[gi] <= rd;
                end
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Read ports: zero register, then write bypass, then array
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NRD; gi++) begin : g_port
            logic [SZB-1:0] ra;
            logic           ra_zero;
            logic           ra_byp;

            assign ra      = addr_rs[gi*SZB +: SZB];
            assign ra_zero = (ZERO_R0 != 0) && (ra == '0);
            assign ra_byp  = we && (addr_rd == ra);

            assign rs_d[gi*BIT +: BIT] = ra_zero ? '0 :
                                         ra_byp  ? rd : regf_q[ra];
            // Busy is taken from the next-state vector so the flag matches
            // whatever data (bypassed or stored) this port returns.
            assign rs_busy_d[gi] = busy_d[ra];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Busy count of the next-state vector
    // -------------------------------------------------------------------------
    always_comb begin
        n_busy_d = '0;
        for (int i = 0; i < SZA; i++) begin
            n_busy_d = n_busy_d + (SZB+1)'(busy_d[i]);
        end
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q    <= '0;
            rs_q      <= '0;
            rs_busy_q <= '0;
            n_busy_q  <= '0;
        end else begin
            busy_q    <= busy_d;
            rs_q      <= rs_d;
            rs_busy_q <= rs_busy_d;
            n_busy_q  <= n_busy_d;
        end
    end

    assign rs      = rs_q;
    assign rs_busy = rs_busy_q;
    assign n_busy  = n_busy_q;

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised multi-read-port data register file with write-to-read bypass, optional hard-wired zero register and a per-register busy scoreboard. It sits between decode and the execute/writeback stages of the CPU datapath. Decode reserves destination registers and reads operands with their busy status. Writeback writes results and clears the matching busy bit.

## Interface
Parameters:
- BIT, 8, data width of each register
- SZB, 4, address width; depth SZA = 2**SZB
- NRD, 2, number of read ports (1..4)
- ZERO_R0, 1, 1: register 0 reads 0, ignores writes, never becomes busy; 0: register 0 is ordinary

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- we  in  1  write enable (writeback)
- addr_rd  in  SZB  write address
- rd  in  BIT  write data
- rsv  in  1  reserve request: mark addr_rsv busy
- addr_rsv  in  SZB  register to reserve
- addr_rs  in  NRD*SZB  read addresses; port i at [SZB*(i+1)-1 : SZB*i]
- rs  out  NRD*BIT  registered read data; port i at [BIT*(i+1)-1 : BIT*i]
- rs_busy  out  NRD  registered busy flag per read port
- n_busy  out  SZB+1  registered count of busy registers (0..SZA)

## Operation
- Storage: SZA x BIT data array plus SZA-bit busy vector.
- Reset (async): all registers 0, busy vector 0, rs 0, rs_busy 0, n_busy 0.
- Write: if we, regf[addr_rd] <= rd. When ZERO_R0=1 and addr_rd=0, the write is dropped.
- Busy next-state for register a, per cycle, evaluated in priority order:
  - ZERO_R0=1 and a=0: 0.
  - rsv and addr_rsv=a: 1. Reserve wins over a same-cycle write to the same register; the new producer owns it, and the data is still written.
  - we and addr_rd=a: 0.
  - Otherwise: hold.
- Reserving an already-busy register keeps it busy (WAW allowed); n_busy does not change.
- Read port i, registered every cycle, where a = addr_rs[i]:
  - ZERO_R0=1 and a=0: rs[i] <= 0.
  - Else if we and addr_rd=a (bypass): rs[i] <= rd.
  - Else: rs[i] <= regf[a].
- rs_busy[i] <= busy next-state of addr_rs[i]. The flag is consistent with the bypassed data.
- n_busy <= popcount of the busy next-state vector.
  - Per-cycle change is in {-1, 0, +1}.
  - Reserve and clear of different registers in the same cycle net to 0.
- All read ports are independent. Identical addresses on several ports return identical data.

## Timing
- Write latency: data is visible through the array one cycle after the we edge. It is visible on rs in the same edge via the bypass.
- Read latency: 1 cycle. addr_rs sampled at edge N appears on rs/rs_busy after edge N.
- Busy latency: rsv at edge N sets the bit at N; a read of that register issued at edge N already reports busy.
- No back-pressure or handshake. Every request is accepted every cycle.
- Reset mid-operation: outputs go to 0 immediately (asynchronously). Requests in flight are discarded. First valid read data appears one edge after reset deasserts.
- Inputs must be stable around the rising edge. No combinational input-to-output paths.

## Test plan
- Reset mid-stream.
  - Stimulus: write 0xA5 to r3, reserve r5, then assert reset for 1 cycle.
  - Required: rs=0, rs_busy=0, n_busy=0 during reset; r3 reads 0x00 afterwards.
- Basic write/read and zero register.
  - Stimulus: write 0x3C to r7, then read r7 on port 0 and r0 on port 1; then write 0xFF to r0 and read it back.
  - Required: port 0 = 0x3C, port 1 = 0x00; r0 still reads 0x00 (ZERO_R0=1). With ZERO_R0=0, r0 reads 0xFF.
- Bypass.
  - Stimulus: same cycle we=1, addr_rd=2, rd=0x81, addr_rs port0=2, port1=2.
  - Required: next cycle both ports = 0x81, where the stale array value was 0x00.
- Scoreboard sequence.
  - Stimulus: rsv r4 and r9 in successive cycles.
  - Required: n_busy 1 then 2.
  - Stimulus: read r4 with we on r4 (rd=0x11) in the same cycle.
  - Required: rs=0x11, rs_busy=0, n_busy=1.
- Simultaneous reserve and write.
  - Stimulus: r6 busy; same cycle rsv r6 and we r6 (rd=0x55), with a read of r6.
  - Required: rs=0x55, rs_busy=1, n_busy unchanged.
  - Stimulus: rsv r8 and we r6 in the same cycle.
  - Required: n_busy unchanged, r6 not busy, r8 busy.
- Full/WAW.
  - Stimulus: SZB=2, ZERO_R0=0; reserve all 4 registers, then reserve r1 again.
  - Required: n_busy=4 and holds at 4.
  - Stimulus: write each register.
  - Required: n_busy counts down to 0.
